// File: rtl/byte_unstrip.sv
// Receive-side merge stage: buffers 4-lane symbol words in a small FIFO and
// re-serialises them as a lane0..lane3 byte stream with a lane-0 framing check.
module byte_unstrip #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET_L,
    input  logic [7:0]               LANE0,
    input  logic [7:0]               LANE1,
    input  logic [7:0]               LANE2,
    input  logic [7:0]               LANE3,
    input  logic                     DK_0,
    input  logic                     DK_1,
    input  logic                     DK_2,
    input  logic                     DK_3,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    output logic [7:0]               D_OUT,
    output logic                     DK_OUT,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT,
    output logic                     ALIGN_ERR
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][7:0]   hold_data_q, hold_data_d;
    logic [3:0]        hold_dk_q, hold_dk_d;
    logic [7:0]        d_out_q, d_out_d;
    logic              dk_out_q, dk_out_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    // FIFO word layout: {dk[3:0], lane3, lane2, lane1, lane0}
    logic [35:0]       mem [DEPTH];
    logic [35:0]       in_word;
    logic [35:0]       head;
    logic [3:0][7:0]   head_data;
    logic [3:0]        head_dk;
    logic              full;
    logic              in_ready;
    logic              push;
    logic              pop;
    logic              head_misframed;
    logic [1:0]        lane_nxt;

    always_comb begin
        in_word   = {DK_3, DK_2, DK_1, DK_0, LANE3, LANE2, LANE1, LANE0};
        full      = (count_q == CW'(DEPTH));
        in_ready  = RESET_L && !full;
        push      = IN_VALID && in_ready;
        head      = mem[rd_ptr_q];
        head_data = head[31:0];
        head_dk   = head[35:32];
        lane_nxt  = idx_q + 2'd1;

        // STP/SDP are only legal on lane 0
        head_misframed = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (head_dk[i] && (head_data[i] == 8'hFB || head_data[i] == 8'h5C)) begin
                head_misframed = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        idx_d       = idx_q;
        hold_data_d = hold_data_q;
        hold_dk_d   = hold_dk_q;
        d_out_d     = d_out_q;
        dk_out_d    = dk_out_q;
        valid_d     = valid_q;
        err_d       = err_q;
        pop         = 1'b0;

        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (OUT_READY) begin
                    if (idx_q != 2'd3) begin
                        idx_d    = lane_nxt;
                        d_out_d  = hold_data_q[lane_nxt];
                        dk_out_d = hold_dk_q[lane_nxt];
                    end else if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            hold_data_d = head_data;
            hold_dk_d   = head_dk;
            idx_d       = 2'd0;
            d_out_d     = head_data[0];
            dk_out_d    = head_dk[0];
            valid_d     = 1'b1;
            rd_ptr_d    = rd_ptr_q + 1'b1;
            if (head_misframed) begin
                err_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            idx_q       <= 2'd0;
            hold_data_q <= '0;
            hold_dk_q   <= '0;
            d_out_q     <= 8'h00;
            dk_out_q    <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            hold_data_q <= hold_data_d;
            hold_dk_q   <= hold_dk_d;
            d_out_q     <= d_out_d;
            dk_out_q    <= dk_out_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // Storage needs no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= in_word;
        end
    end

    assign IN_READY   = in_ready;
    assign D_OUT      = d_out_q;
    assign DK_OUT     = dk_out_q;
    assign OUT_VALID  = valid_q;
    assign FIFO_COUNT = count_q;
    assign ALIGN_ERR  = err_q;

endmodule
